ifid_redirect: RTL and testbench

- Consumer end of the ifetch interface.
- Takes `instruction`/`PC` from ifetch every cycle and drives `branch_pc`/`npc_control` back to it.
- Buffers fetched instructions toward decode in a 2-entry valid/ready queue.
- Redirects fetch for JAL, execute-stage redirects and back-pressure replay. Sits between ifetch and the decode stage.

---
 rtl/if_pkg.sv | 30 +++
 rtl/ifid_fifo2.sv | 65 ++++++
 rtl/ifid_redirect.sv | 117 +++++++++++
 tb/tb_ifid_redirect.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the ifetch -> decode handoff: opcodes, FSM state,
// queue entry layout and immediate decoders.
package if_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // RUN examines the incoming instruction; SQUASH drops the wrong-path one.
    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } if_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred_taken;
    } if_entry_t;

    // J-type immediate: sext{i[31], i[19:12], i[20], i[30:21], 0}
    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // B-type immediate: sext{i[31], i[7], i[30:25], i[11:8], 0}
    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/ifid_fifo2.sv
// Two-entry in-order queue of fetched instructions toward decode.
// Push and pop may coincide at any occupancy; flush empties it and wins over
// a same-cycle push. Head reads as all-zero while empty.
module ifid_fifo2
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  if_entry_t entry_in,
    input  logic      pop,
    input  logic      flush,
    output if_entry_t head,
    output logic      full,
    output logic [1:0] count
);

    logic [1:0] count_q;
    if_entry_t  slot0;
    if_entry_t  slot1;

    // Occupancy counter; flush drops everything after a same-cycle pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage: slot0 is always the head, slot1 the one behind it.
    // NOTE: storage is left unreset; count_q alone qualifies it and the
    // head is masked to zero while empty, so the data flops need no reset.
    always_ff @(posedge clock) begin
        if (pop) begin
            if (push && count_q == 2'd1) begin
                slot0 <= entry_in;
            end else begin
                slot0 <= slot1;
            end
            if (push && count_q == 2'd2) begin
                slot1 <= entry_in;
            end
        end else if (push) begin
            if (count_q == 2'd0) begin
                slot0 <= entry_in;
            end else begin
                slot1 <= entry_in;
            end
        end
    end

    assign head  = (count_q != 2'd0) ? slot0 : '0;
    assign full  = (count_q == 2'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/ifid_redirect.sv
// Consumer end of the ifetch interface. Accepts one instruction per cycle,
// buffers it toward decode, and redirects fetch for JAL, execute-stage
// flushes and back-pressure replay (refetch of the instruction that found
// the queue full). Every redirect costs one squashed wrong-path cycle.
// Optional: define STATIC_BTFN_EN to predict backward B-type branches taken.
module ifid_redirect
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc,
    output logic [31:0] branch_pc,
    output logic        npc_control,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic        id_pred_taken,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target
);

    if_state_t   state;
    if_entry_t   in_entry;
    if_entry_t   head;
    logic [1:0]  count;
    logic [6:0]  opcode;
    logic [31:0] target;
    logic        full;
    logic        pop;
    logic        push;
    logic        flush;
    logic        redirect;
    logic        pred;

    assign opcode = if_instruction[6:0];
    assign pop    = id_valid & id_ready;

    // Per-cycle decision: execute flush, then replay, then accept.
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        push     = 1'b0;
        flush    = 1'b0;
        redirect = 1'b0;
        pred     = 1'b0;
        target   = branch_pc;
        if (ex_redirect) begin
            flush    = 1'b1;
            redirect = 1'b1;
            target   = ex_target;
        end else if (state == RUN) begin
            if (full && !pop) begin
                redirect = 1'b1;
                target   = if_pc;
            end else begin
                push = 1'b1;
                if (opcode == OPC_JAL) begin
                    redirect = 1'b1;
                    pred     = 1'b1;
                    target   = if_pc + imm_j(if_instruction);
                end
`ifdef STATIC_BTFN_EN
                else if (opcode == OPC_BRANCH && if_instruction[31]) begin
                    redirect = 1'b1;
                    pred     = 1'b1;
                    target   = if_pc + imm_b(if_instruction);
                end
`endif
            end
        end
    end

    assign in_entry = '{instr: if_instruction, pc: if_pc, pred_taken: pred};

    ifid_fifo2 #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .entry_in(in_entry),
        .pop     (pop),
        .flush   (flush),
        .head    (head),
        .full    (full),
        .count   (count)
    );

    assign id_valid       = (count != 2'd0);
    assign id_instruction = head.instr;
    assign id_pc          = head.pc;
    assign id_pred_taken  = head.pred_taken;

    // Redirect registers and FSM: a redirect strobes npc_control and
    // squashes exactly the next incoming instruction.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            npc_control <= 1'b0;
            branch_pc   <= RESET_PC;
        end else begin
            npc_control <= redirect;
            state       <= redirect ? SQUASH : RUN;
            if (redirect) begin
                branch_pc <= target;
            end
        end
    end

endmodule

// File: tb/tb_ifid_redirect.sv
// Self-checking bench for ifid_redirect. An ifetch model drives PC/instruction
// from a program image; a scoreboard checks that decode sees exactly the
// architectural instruction stream (program order, redirect targets, no
// duplicates, no wrong-path entries) plus directed timing checks.
module tb_ifid_redirect;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_instruction = NOP;
    logic [31:0] if_pc = 32'h0;
    logic [31:0] branch_pc;
    logic        npc_control;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = 32'h0;

    always #5 clock = ~clock;

    ifid_redirect dut (
        .clock         (clock),
        .reset         (reset),
        .if_instruction(if_instruction),
        .if_pc         (if_pc),
        .branch_pc     (branch_pc),
        .npc_control   (npc_control),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instruction(id_instruction),
        .id_pc         (id_pc),
        .id_pred_taken (id_pred_taken),
        .ex_redirect   (ex_redirect),
        .ex_target     (ex_target)
    );

    int errors = 0;
    int checks = 0;

    // Program image and its architectural successor / prediction per PC.
    logic [31:0] imem     [logic [31:0]];
    logic [31:0] succ_map [logic [31:0]];
    logic        pred_map [logic [31:0]];

    logic [31:0] fetch_pc;
    logic [31:0] exp_next_pc;
    logic [31:0] delivered[$];
    logic        mon_en = 1'b0;
    logic        prev_stall;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic        prev_pred;

    function automatic logic [31:0] imem_read(input logic [31:0] pc);
        return imem.exists(pc) ? imem[pc] : NOP;
    endfunction

    function automatic logic [31:0] succ_of(input logic [31:0] pc);
        return succ_map.exists(pc) ? succ_map[pc] : pc + 32'd4;
    endfunction

    function automatic logic pred_of(input logic [31:0] pc);
        return pred_map.exists(pc) ? pred_map[pc] : 1'b0;
    endfunction

    // Encoders build instructions from a byte offset, independent of any decoder.
    function automatic logic [31:0] enc_jal(input logic [31:0] off);
        return {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [31:0] off);
        return {off[12], off[10:5], 5'd2, 5'd1, 3'b000, off[4:1], off[11], 7'b1100011};
    endfunction

    task automatic add_jal(input logic [31:0] pc, input logic [31:0] off);
        imem[pc]     = enc_jal(off);
        succ_map[pc] = pc + off;
        pred_map[pc] = 1'b1;
    endtask

    task automatic add_beq(input logic [31:0] pc, input logic [31:0] off);
        imem[pc] = enc_beq(off);
`ifdef STATIC_BTFN_EN
        if (off[31]) begin
            succ_map[pc] = pc + off;
            pred_map[pc] = 1'b1;
        end
`endif
    endtask

    task automatic clear_prog();
        imem.delete();
        succ_map.delete();
        pred_map.delete();
    endtask

    // Hold reset for one edge, then present start_pc in the first cycle after release.
    task automatic restart(input logic [31:0] start_pc);
        mon_en      = 1'b0;
        reset       = 1'b1;
        id_ready    = 1'b0;
        ex_redirect = 1'b0;
        ex_target   = 32'h0;
        @(posedge clock);
        #1;
        fetch_pc       = start_pc;
        if_pc          = start_pc;
        if_instruction = imem_read(start_pc);
        exp_next_pc    = start_pc;
        delivered.delete();
        prev_stall     = 1'b0;
        reset          = 1'b0;
        mon_en         = 1'b1;
    endtask

    // One clock: scoreboard at negedge, then ifetch model advances after posedge.
    task automatic cycle();
        logic        npc;
        logic [31:0] bpc;
        @(negedge clock);
        if (mon_en && !reset) begin
            if (id_valid) begin
                if (prev_stall) begin
                    checks++;
                    if (id_pc !== prev_pc || id_instruction !== prev_instr || id_pred_taken !== prev_pred) begin
                        errors++;
                        $display("FAIL head_stable: got pc=%h instr=%h pred=%b expected pc=%h instr=%h pred=%b",
                                 id_pc, id_instruction, id_pred_taken, prev_pc, prev_instr, prev_pred);
                    end
                end
                if (id_ready) begin
                    checks++;
                    if (id_pc !== exp_next_pc) begin
                        errors++;
                        $display("FAIL deliver_pc: got %h expected %h", id_pc, exp_next_pc);
                    end
                    checks++;
                    if (id_instruction !== imem_read(id_pc)) begin
                        errors++;
                        $display("FAIL deliver_instr: got %h expected %h", id_instruction, imem_read(id_pc));
                    end
                    checks++;
                    if (id_pred_taken !== pred_of(id_pc)) begin
                        errors++;
                        $display("FAIL deliver_pred: pc=%h got %b expected %b", id_pc, id_pred_taken, pred_of(id_pc));
                    end
                    delivered.push_back(id_pc);
                    exp_next_pc = succ_of(id_pc);
                end
            end else begin
                checks++;
                if (id_pc !== 32'h0 || id_instruction !== 32'h0 || id_pred_taken !== 1'b0) begin
                    errors++;
                    $display("FAIL empty_zero: got pc=%h instr=%h pred=%b expected all zero",
                             id_pc, id_instruction, id_pred_taken);
                end
            end
            if (ex_redirect) begin
                exp_next_pc = ex_target;
            end
            prev_stall = id_valid && !id_ready && !ex_redirect;
            prev_pc    = id_pc;
            prev_instr = id_instruction;
            prev_pred  = id_pred_taken;
        end
        npc = npc_control;
        bpc = branch_pc;
        @(posedge clock);
        #1;
        fetch_pc       = npc ? bpc : fetch_pc + 32'd4;
        if_pc          = fetch_pc;
        if_instruction = imem_read(fetch_pc);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (npc_control !== 1'b0 || branch_pc !== 32'h0) begin
            errors++;
            $display("FAIL %s_redirect: got npc=%b bpc=%h expected npc=0 bpc=00000000", tag, npc_control, branch_pc);
        end
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instruction !== 32'h0 || id_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL %s_head: got v=%b pc=%h instr=%h pred=%b expected all zero",
                     tag, id_valid, id_pc, id_instruction, id_pred_taken);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
    endtask

    task automatic test_straight();
        clear_prog();
        restart(32'h0);
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(i * 4)) begin
                errors++;
                $display("FAIL straight_pc%0d: got v=%b pc=%h expected v=1 pc=%h", i, id_valid, id_pc, 32'(i * 4));
            end
            checks++;
            if (npc_control !== 1'b0) begin
                errors++;
                $display("FAIL straight_npc%0d: got %b expected 0", i, npc_control);
            end
        end
    endtask

    task automatic test_jal();
        clear_prog();
        add_jal(32'h10, 32'h20);
        restart(32'h10);
        id_ready = 1'b1;
        cycle();
        checks++;
        if (npc_control !== 1'b1 || branch_pc !== 32'h30) begin
            errors++;
            $display("FAIL jal_redirect: got npc=%b bpc=%h expected npc=1 bpc=00000030", npc_control, branch_pc);
        end
        checks++;
        if (id_pc !== 32'h10 || id_pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL jal_entry: got pc=%h pred=%b expected pc=00000010 pred=1", id_pc, id_pred_taken);
        end
        cycle();
        checks++;
        if (npc_control !== 1'b0 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL jal_bubble: got npc=%b v=%b expected npc=0 v=0", npc_control, id_valid);
        end
        cycle();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h30) begin
            errors++;
            $display("FAIL jal_target: got v=%b pc=%h expected v=1 pc=00000030", id_valid, id_pc);
        end
    endtask

    task automatic test_backpressure();
        clear_prog();
        restart(32'h40);
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (i == 2) begin
                checks++;
                if (npc_control !== 1'b1 || branch_pc !== 32'h48) begin
                    errors++;
                    $display("FAIL replay_redirect: got npc=%b bpc=%h expected npc=1 bpc=00000048", npc_control, branch_pc);
                end
            end
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h40) begin
            errors++;
            $display("FAIL replay_hold: got v=%b pc=%h expected v=1 pc=00000040", id_valid, id_pc);
        end
        id_ready = 1'b1;
        repeat (8) cycle();
        checks++;
        if (delivered.size() < 3) begin
            errors++;
            $display("FAIL replay_count: got %0d deliveries expected at least 3", delivered.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (delivered[i] !== 32'h40 + 32'(i * 4)) begin
                    errors++;
                    $display("FAIL replay_order%0d: got %h expected %h", i, delivered[i], 32'h40 + 32'(i * 4));
                end
            end
        end
    endtask

    task automatic test_ex_redirect();
        clear_prog();
        add_jal(32'h208, 32'h40);
        restart(32'h200);
        id_ready = 1'b0;
        repeat (2) cycle();
        id_ready    = 1'b1;
        ex_redirect = 1'b1;
        ex_target   = 32'h100;
        cycle();
        ex_redirect = 1'b0;
        checks++;
        if (npc_control !== 1'b1 || branch_pc !== 32'h100) begin
            errors++;
            $display("FAIL ex_redirect: got npc=%b bpc=%h expected npc=1 bpc=00000100", npc_control, branch_pc);
        end
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL ex_flush: got v=%b expected 0", id_valid);
        end
        repeat (3) cycle();
        checks++;
        if (delivered.size() < 2 || delivered[0] !== 32'h200 || delivered[1] !== 32'h100) begin
            errors++;
            $display("FAIL ex_next: got %0d deliveries, second=%h expected 00000200 then 00000100",
                     delivered.size(), (delivered.size() > 1) ? delivered[1] : 32'hx);
        end
    endtask

    task automatic test_wrap_and_async_reset();
        clear_prog();
        add_jal(32'hFFFF_FFF0, 32'h20);
        restart(32'hFFFF_FFF0);
        id_ready = 1'b1;
        cycle();
        checks++;
        if (npc_control !== 1'b1 || branch_pc !== 32'h0000_0010) begin
            errors++;
            $display("FAIL wrap_target: got npc=%b bpc=%h expected npc=1 bpc=00000010", npc_control, branch_pc);
        end
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        clear_prog();
        restart(32'h0);
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (npc_control !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_npc%0d: got %b expected 0", i, npc_control);
            end
        end
    endtask

    task automatic test_btfn();
        clear_prog();
        add_beq(32'h80, 32'hFFFF_FFF8);
        restart(32'h80);
        id_ready = 1'b1;
        cycle();
        checks++;
        if (id_pc !== 32'h80 || id_instruction !== enc_beq(32'hFFFF_FFF8)) begin
            errors++;
            $display("FAIL btfn_entry: got pc=%h instr=%h expected pc=00000080", id_pc, id_instruction);
        end
`ifdef STATIC_BTFN_EN
        checks++;
        if (npc_control !== 1'b1 || branch_pc !== 32'h78 || id_pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL btfn_taken: got npc=%b bpc=%h pred=%b expected npc=1 bpc=00000078 pred=1",
                     npc_control, branch_pc, id_pred_taken);
        end
`else
        checks++;
        if (npc_control !== 1'b0 || id_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL btfn_off: got npc=%b pred=%b expected npc=0 pred=0", npc_control, id_pred_taken);
        end
`endif
        repeat (4) cycle();
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] off;
        clear_prog();
        for (int a = 0; a < 32'h400; a += 4) begin
            r = 32'($urandom_range(0, 99));
            if (r < 10) begin
                off = (32'($urandom_range(0, 255)) << 2) - 32'(a);
                add_jal(32'(a), off);
            end else if (r < 22) begin
                off = 32'($urandom_range(1, 16)) << 2;
                if ($urandom_range(0, 1) == 1 && 32'(a) >= off) off = -off;
                else if (32'(a) + off >= 32'h400) off = -off;
                add_beq(32'(a), off);
            end else begin
                r = $urandom();
                r[6:0] = 7'b0010011;
                imem[32'(a)] = r;
            end
        end
        restart(32'h0);
        for (int i = 0; i < 3000; i++) begin
            id_ready    = ($urandom_range(0, 99) < 70);
            ex_redirect = ($urandom_range(0, 99) < 3);
            ex_target   = 32'($urandom_range(0, 255)) << 2;
            cycle();
        end
        ex_redirect = 1'b0;
        checks++;
        if (delivered.size() < 300) begin
            errors++;
            $display("FAIL random_progress: got %0d deliveries expected at least 300", delivered.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_straight();
        test_jal();
        test_backpressure();
        test_ex_redirect();
        test_wrap_and_async_reset();
        test_btfn();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
